// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: widths, x0, ALU-op encodings, EX control bundle.
// Types only; no timing or flow-control behaviour.
package pipe_pkg;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int AOPW = 4;

   localparam logic [RW-1:0] REG_ZERO = '0;

   localparam logic [AOPW-1:0] ALU_ADD = 4'd0;
   localparam logic [AOPW-1:0] ALU_SUB = 4'd1;
   localparam logic [AOPW-1:0] ALU_AND = 4'd2;
   localparam logic [AOPW-1:0] ALU_OR  = 4'd3;
   localparam logic [AOPW-1:0] ALU_XOR = 4'd4;
   localparam logic [AOPW-1:0] ALU_SLT = 4'd5;
   localparam logic [AOPW-1:0] ALU_SLL = 4'd6;
   localparam logic [AOPW-1:0] ALU_SRL = 4'd7;

   typedef struct packed {
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic            alusrc;
      logic [AOPW-1:0] aluop;
   } ex_ctrl_t;

   localparam ex_ctrl_t EX_CTRL_NOP = '0;

   // x0 is hardwired, so a WB write to it must never be bypassed.
   function automatic logic wb_hit(input logic we, input logic [RW-1:0] wrd,
                                   input logic [RW-1:0] rs);
      return we && (wrd != REG_ZERO) && (wrd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode fields, WB bypass, flush/stall and EX outputs.
// master = front-end/testbench side, slave = id_ex_stage.
interface id_ex_stage_if;
   import pipe_pkg::*;

   logic            id_valid;
   logic [RW-1:0]   id_rs1, id_rs2, id_rd;
   logic            id_uses_rs2;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic            id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
   logic [AOPW-1:0] id_aluop;
   logic            wb_regwrite;
   logic [RW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            stall;
   logic            ex_valid;
   logic [RW-1:0]   ex_rrs1, ex_rrs2, ex_rd;
   logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
   logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
   logic [AOPW-1:0] ex_aluop;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
             id_alusrc, id_aluop, wb_regwrite, wb_rd, wb_data, flush,
      input  stall, ex_valid, ex_rrs1, ex_rrs2, ex_rd, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_pc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
             ex_alusrc, ex_aluop
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
             id_alusrc, id_aluop, wb_regwrite, wb_rd, wb_data, flush,
      output stall, ex_valid, ex_rrs1, ex_rrs2, ex_rd, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_pc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
             ex_alusrc, ex_aluop
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard: a load in EX whose rd feeds a source of the decode slot.
// Purely combinational, 0 cycles; no flow control of its own.
module load_use_detect #(
   parameter int RW = 5
) (
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic          id_uses_rs2,
   input  logic          ex_valid,
   input  logic          ex_memread,
   input  logic [RW-1:0] ex_rd,
   output logic          hazard
);

   logic rd_nz;
   logic rs1_match;
   logic rs2_match;

   assign rd_nz     = (ex_rd != {RW{1'b0}});
   assign rs1_match = (ex_rd == id_rs1);
   assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
   assign hazard    = id_valid && ex_valid && ex_memread && rd_nz && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubble, branch squash and WB->ID operand bypass; 1-cycle latency.
// Backpressure: stall holds PC/IF-ID for one cycle on load-use; optional ID_EX_STALL_CNT_EN adds counters.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RW   = 5,
   parameter int AOPW = 4
) (
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]  stall_cnt,
   output logic [31:0]  flush_cnt
`endif
);
   import pipe_pkg::*;

   logic            hazard;
   logic            bubble;
   logic            ex_valid_q;
   logic [RW-1:0]   rrs1_q, rrs2_q, rd_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
   ex_ctrl_t        ctrl_q;
   ex_ctrl_t        id_ctrl;
   logic [AOPW-1:0] id_aluop_w;
   logic [XLEN-1:0] rs1_byp, rs2_byp;

   load_use_detect #(.RW(RW)) u_load_use_detect (
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .id_uses_rs2 (bus.id_uses_rs2),
      .ex_valid    (ex_valid_q),
      .ex_memread  (ctrl_q.memread),
      .ex_rd       (rd_q),
      .hazard      (hazard)
   );

   // Flush discards IF/ID anyway, so holding it would only waste a cycle.
   assign bus.stall = hazard && !bus.flush;
   assign bubble    = hazard || bus.flush;

   assign id_aluop_w = bus.id_aluop;
   always_comb begin
      id_ctrl          = EX_CTRL_NOP;
      id_ctrl.regwrite = bus.id_regwrite;
      id_ctrl.memread  = bus.id_memread;
      id_ctrl.memwrite = bus.id_memwrite;
      id_ctrl.memtoreg = bus.id_memtoreg;
      id_ctrl.alusrc   = bus.id_alusrc;
      id_ctrl.aluop    = id_aluop_w;
   end

   assign rs1_byp = wb_hit(bus.wb_regwrite, bus.wb_rd, bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
   assign rs2_byp = wb_hit(bus.wb_regwrite, bus.wb_rd, bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         rrs1_q     <= '0;
         rrs2_q     <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         ctrl_q     <= EX_CTRL_NOP;
      end else if (bubble) begin
         ex_valid_q <= 1'b0;
         rrs1_q     <= '0;
         rrs2_q     <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         ctrl_q     <= EX_CTRL_NOP;
      end else begin
         ex_valid_q <= bus.id_valid;
         rrs1_q     <= bus.id_rs1;
         // An unused rs2 reads as x0 so the forwarding selector ignores it.
         rrs2_q     <= bus.id_uses_rs2 ? bus.id_rs2 : '0;
         rd_q       <= bus.id_rd;
         rs1_data_q <= rs1_byp;
         rs2_data_q <= rs2_byp;
         imm_q      <= bus.id_imm;
         pc_q       <= bus.id_pc;
         ctrl_q     <= bus.id_valid ? id_ctrl : EX_CTRL_NOP;
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_rrs1     = rrs1_q;
   assign bus.ex_rrs2     = rrs2_q;
   assign bus.ex_rd       = rd_q;
   assign bus.ex_rs1_data = rs1_data_q;
   assign bus.ex_rs2_data = rs2_data_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_pc       = pc_q;
   assign bus.ex_regwrite = ctrl_q.regwrite;
   assign bus.ex_memread  = ctrl_q.memread;
   assign bus.ex_memwrite = ctrl_q.memwrite;
   assign bus.ex_memtoreg = ctrl_q.memtoreg;
   assign bus.ex_alusrc   = ctrl_q.alusrc;
   assign bus.ex_aluop    = ctrl_q.aluop;

`ifdef ID_EX_STALL_CNT_EN
   // Saturating event counters for performance monitoring.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
         if (bus.flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected EX state, a monitor compares after each edge.
module tb_id_ex_stage;

   typedef struct packed {
      logic        v;
      logic [4:0]  rs1, rs2, rd;
      logic        uses;
      logic [31:0] d1, d2, imm, pc;
      logic [4:0]  ctl;
      logic [3:0]  op;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic [4:0]  rrs1, rrs2, rd;
      logic [31:0] d1, d2, imm, pc;
      logic [4:0]  ctl;
      logic [3:0]  op;
   } ex_t;

   localparam logic [4:0] LW = 5'b11011;
   localparam logic [4:0] RT = 5'b10000;
   localparam logic [4:0] IT = 5'b10001;
   localparam ex_t BUB = '0;

   logic clk;
   logic rst;
   int   ncmp;
   int   nbad;
   int   step_no;
   ex_t  sb[$];

   id_ex_stage_if bus();

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t id_v(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic uses, logic [31:0] d1, logic [31:0] d2,
                                 logic [31:0] imm, logic [31:0] pc, logic [4:0] ctl, logic [3:0] op);
      return '{v, rs1, rs2, rd, uses, d1, d2, imm, pc, ctl, op};
   endfunction

   function automatic ex_t ex_of(logic v, logic [4:0] rrs1, logic [4:0] rrs2, logic [4:0] rd,
                                 logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                 logic [31:0] pc, logic [4:0] ctl, logic [3:0] op);
      return '{v, rrs1, rrs2, rd, d1, d2, imm, pc, ctl, op};
   endfunction

   function automatic ex_t act();
      return '{bus.ex_valid, bus.ex_rrs1, bus.ex_rrs2, bus.ex_rd, bus.ex_rs1_data,
               bus.ex_rs2_data, bus.ex_imm, bus.ex_pc,
               {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_alusrc},
               bus.ex_aluop};
   endfunction

   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
      ncmp++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s (step %0d): got %h required %h", name, step_no, got, want);
      end
   endtask

   task automatic drive(input vec_t x, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic fl);
      bus.id_valid    = x.v;
      bus.id_rs1      = x.rs1;
      bus.id_rs2      = x.rs2;
      bus.id_rd       = x.rd;
      bus.id_uses_rs2 = x.uses;
      bus.id_rs1_data = x.d1;
      bus.id_rs2_data = x.d2;
      bus.id_imm      = x.imm;
      bus.id_pc       = x.pc;
      {bus.id_regwrite, bus.id_memread, bus.id_memwrite, bus.id_memtoreg, bus.id_alusrc} = x.ctl;
      bus.id_aluop    = x.op;
      bus.wb_regwrite = we;
      bus.wb_rd       = wrd;
      bus.wb_data     = wd;
      bus.flush       = fl;
   endtask

   task automatic step(input vec_t x, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic fl, input logic exp_stall, input ex_t exp);
      @(negedge clk);
      step_no++;
      drive(x, we, wrd, wd, fl);
      #1;
      chk("stall", 160'(bus.stall), 160'(exp_stall));
      sb.push_back(exp);
      @(posedge clk);
   endtask

   // Monitor: compares the registered EX state just after every rising edge.
   initial begin
      ex_t e;
      ex_t a;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            a = act();
            chk("ex_state", 160'(a), 160'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   initial begin
      vec_t add_dep;
      ncmp = 0;
      nbad = 0;
      step_no = 0;
      rst = 1'b1;
      drive('0, 1'b0, 5'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("reset_ex", 160'(act()), 160'(BUB));
      chk("reset_stall", 160'(bus.stall), 160'(1'b0));
      @(negedge clk);
      rst = 1'b0;

      // lw x5 then dependent add: one bubble, then the add
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h10,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h10,LW,0));
      add_dep = id_v(1,5,7,6,1,'h55,'h77,0,'h14,RT,0);
      step(add_dep, 0,0,0, 0, 1, BUB);
      step(add_dep, 0,0,0, 0, 0, ex_of(1,5,7,6,'h55,'h77,0,'h14,RT,0));
      // lw x5 then independent add
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h18,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h18,LW,0));
      step(id_v(1,3,4,8,1,3,4,0,'h1c,RT,1), 0,0,0, 0, 0, ex_of(1,3,4,8,3,4,0,'h1c,RT,1));
      // lw x5 then I-type whose unused rs2 field is 5
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h20,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h20,LW,0));
      step(id_v(1,2,5,9,0,2,'h5555,7,'h24,IT,0), 0,0,0, 0, 0, ex_of(1,2,0,9,2,'h5555,7,'h24,IT,0));
      // load to x0, then reader of x0
      step(id_v(1,1,0,0,0,'h100,0,0,'h28,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,0,'h100,0,0,'h28,LW,0));
      step(id_v(1,0,0,10,1,0,0,0,'h2c,RT,0), 0,0,0, 0, 0, ex_of(1,0,0,10,0,0,0,'h2c,RT,0));
      // WB bypass on rs1, suppressed for x0, then on rs2
      step(id_v(1,9,3,11,1,0,'h33,0,'h30,RT,0), 1,9,'hDEADBEEF, 0, 0, ex_of(1,9,3,11,'hDEADBEEF,'h33,0,'h30,RT,0));
      step(id_v(1,0,3,12,1,0,'h33,0,'h34,RT,0), 1,0,'hDEADBEEF, 0, 0, ex_of(1,0,3,12,0,'h33,0,'h34,RT,0));
      step(id_v(1,1,9,13,1,1,2,0,'h38,RT,0), 1,9,'hDEADBEEF, 0, 0, ex_of(1,1,9,13,1,'hDEADBEEF,0,'h38,RT,0));
      // flush during hazard wins
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h3c,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h3c,LW,0));
      step(id_v(1,5,7,6,1,'h55,'h77,0,'h40,RT,0), 0,0,0, 1, 0, BUB);
      // invalid decode slot behind a load: no stall, controls forced to 0
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h44,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h44,LW,0));
      step(id_v(0,5,6,7,1,9,'ha,0,'h48,RT,3), 0,0,0, 0, 0, ex_of(0,5,6,7,9,'ha,0,'h48,5'b0,0));
      // hazard through rs2
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h4c,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h4c,LW,0));
      step(id_v(1,1,5,14,1,'h1,'h2,0,'h50,RT,2), 0,0,0, 0, 1, BUB);
      step(id_v(1,1,5,14,1,'h1,'h2,0,'h50,RT,2), 0,0,0, 0, 0, ex_of(1,1,5,14,'h1,'h2,0,'h50,RT,2));

      // reset asserted mid-stall
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h58,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h58,LW,0));
      add_dep = id_v(1,5,7,6,1,'h55,'h77,0,'h5c,RT,0);
      @(negedge clk);
      step_no++;
      drive(add_dep, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("pre_reset_stall", 160'(bus.stall), 160'(1'b1));
      #1;
      rst = 1'b1;
      #1;
      chk("async_reset_ex", 160'(act()), 160'(BUB));
      chk("reset_stall_mid", 160'(bus.stall), 160'(1'b0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset_stall", 160'(bus.stall), 160'(1'b0));
      step(add_dep, 0,0,0, 0, 0, ex_of(1,5,7,6,'h55,'h77,0,'h5c,RT,0));
      step(add_dep, 0,0,0, 1, 0, BUB);
      step(id_v(1,1,0,5,0,'h100,'h11,0,'h60,LW,0), 0,0,0, 0, 0, ex_of(1,1,0,5,'h100,'h11,0,'h60,LW,0));
      step(id_v(1,5,7,6,1,'h55,'h77,0,'h64,RT,0), 0,0,0, 0, 1, BUB);
      step(id_v(1,5,7,6,1,'h55,'h77,0,'h64,RT,0), 0,0,0, 0, 0, ex_of(1,5,7,6,'h55,'h77,0,'h64,RT,0));

      @(negedge clk);
      drive('0, 1'b0, 5'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 160'(sb.size()), 160'(0));
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cnt", 160'(stall_cnt), 160'(1));
      chk("flush_cnt", 160'(flush_cnt), 160'(1));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
